plot_readback: RTL and testbench
================================

Name: plot_readback

Overview:
- Receiving end of the pixel-plot interface (vga_x / vga_y / vga_colour / vga_plot) that the drawing sequencers (fillscreen, circle) drive into the VGA adapter.
- Sits in parallel with vga_adapter on the same plot bus and keeps a shadow framebuffer of every accepted write.
- On request, reads the shadow framebuffer back in raster order: streams each pixel, counts pixels matching a chosen colour, and computes a checksum.
- Gives the team on-chip self-check of drawing results (HEX/LEDR display or bench comparison).

Parameters:
- WIDTH, 160, pixels per row; x accepted when < WIDTH.
- HEIGHT, 120, rows; y accepted when < HEIGHT.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour {R,G,B}.
- vga_plot  in  1  write strobe; one pixel per cycle when high.
- scan_start  in  1  level request to begin a readback scan.
- scan_colour  in  3  colour to count; sampled when a scan begins.
- scan_done  out  1  scan finished; held until scan_start drops.
- rd_valid  out  1  rd_x / rd_y / rd_colour valid this cycle.
- rd_x  out  8  x of streamed pixel.
- rd_y  out  7  y of streamed pixel.
- rd_colour  out  3  colour of streamed pixel.
- match_count  out  15  pixels equal to the latched scan_colour.
- checksum  out  16  sum of all pixel colour values, mod 2^16.
- oob_count  out  8  saturating count of dropped out-of-range plots.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - scan_done, rd_valid, rd_x, rd_y, rd_colour, match_count, checksum, oob_count all = 0.
  - Shadow RAM contents are not cleared.
- Storage:
  - WIDTH*HEIGHT x 3-bit simple dual-port RAM.
  - Address = y*WIDTH + x, computed without truncation (15 bits).
  - Write port and read port are independent.
  - Read latency is 1 cycle.
  - Read and write to the same address in the same cycle: read returns the OLD data.
- Write path (active in every state, including during a scan):
  - vga_plot=1 with x<WIDTH and y<HEIGHT: write vga_colour to RAM.
  - vga_plot=1 with x or y out of range: no write; oob_count += 1, saturating at 255.
  - oob_count clears only on reset.
- IDLE:
  - When scan_start=1: latch scan_colour, clear match_count and checksum, zero the read address counters, go to SCAN.
- SCAN:
  - Issues one read address per cycle in raster order: x 0..WIDTH-1 inner, y 0..HEIGHT-1 outer.
  - One cycle after each address: rd_valid=1 with rd_x/rd_y equal to that address and rd_colour equal to the RAM data.
  - On each rd_valid cycle: match_count += (rd_colour == latched colour); checksum += rd_colour.
  - After issuing the last address (WIDTH-1, HEIGHT-1): go to FLUSH.
- FLUSH:
  - One cycle; delivers the last rd_valid beat. Next state DONE.
- DONE:
  - scan_done=1 and rd_valid=0.
  - match_count and checksum hold their final values.
  - When scan_start=0: go to IDLE; scan_done drops the cycle after.
- Timing:
  - With scan_start sampled high in IDLE at edge 0, the first rd_valid occurs at edge 2.
  - Exactly WIDTH*HEIGHT (19200) rd_valid beats are produced.
  - scan_done rises at edge 19202.
- scan_start dropping mid-scan: ignored; the scan always completes.
- rd_x / rd_y / rd_colour hold their last values when rd_valid=0.
- Reset mid-scan: immediate return to IDLE with reset values. The next scan starts from address 0.

Test Plan:
- Reset, then plot all 19200 pixels RED (3'b100), then scan with scan_colour=RED -> match_count=19200, checksum=11264 (76800 mod 65536), exactly 19200 rd_valid beats, scan_done at edge 19202.
- After the RED fill, plot (159,119) GREEN, then scan with scan_colour=GREEN -> match_count=1; final rd_valid beat shows x=159, y=119, colour=3'b010.
- Plot (160,0), (0,120) and (255,127) -> oob_count=3 and RAM unchanged (RED scan still gives 19200). Then 300 out-of-range plots -> oob_count=255.
- During a scan of all-BLACK RAM, plot (0,0) WHITE in the same cycle address 0 is read -> rd_colour for (0,0)=0 in that scan; the next scan shows 3'b111 at (0,0) and checksum=7.
- Hold scan_start=1 through DONE -> scan_done stays 1 and no new scan starts. Drop scan_start -> IDLE. Raise scan_start again -> match_count and checksum restart from 0.
- Assert rst_n=0 at rd beat 5000 -> all outputs 0 and state IDLE. The next scan's first beat is (0,0).

Source files
------------

// File: rtl/plot_readback.sv
// ============================================================================
// Module   : plot_readback
// Purpose  : Shadow framebuffer on the VGA plot bus with raster-order readback,
//            colour match counting and checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_readback #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        scan_start,
    input  logic [2:0]  scan_colour,
    output logic        scan_done,
    output logic        rd_valid,
    output logic [7:0]  rd_x,
    output logic [6:0]  rd_y,
    output logic [2:0]  rd_colour,
    output logic [14:0] match_count,
    output logic [15:0] checksum,
    output logic [7:0]  oob_count
);

    localparam int DEPTH = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  scan_x_q, scan_x_d;
    logic [6:0]  scan_y_q, scan_y_d;
    logic [2:0]  key_colour_q, key_colour_d;
    logic        pipe_valid_q, pipe_valid_d;
    logic [7:0]  pipe_x_q, pipe_x_d;
    logic [6:0]  pipe_y_q, pipe_y_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_x_q, rd_x_d;
    logic [6:0]  rd_y_q, rd_y_d;
    logic [2:0]  rd_colour_q, rd_colour_d;
    logic [14:0] match_q, match_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  oob_q, oob_d;
    logic        done_q, done_d;

    logic [2:0]  ram [0:DEPTH-1];
    logic [2:0]  ram_rdata_q;

    logic        in_range;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic        scan_last;

    assign in_range  = ({1'b0, vga_x} < 9'(WIDTH)) && ({1'b0, vga_y} < 8'(HEIGHT));
    assign wr_en     = vga_plot && in_range;
    assign wr_addr   = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign rd_addr   = 15'(scan_y_q) * 15'(WIDTH) + 15'(scan_x_q);
    assign rd_en     = (state_q == S_SCAN);
    assign scan_last = (scan_x_q == 8'(WIDTH - 1)) && (scan_y_q == 7'(HEIGHT - 1));

    // Nonblocking read and write give old-data semantics on an address collision.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            ram[wr_addr] <= vga_colour;
        end
        if (rd_en) begin
            ram_rdata_q <= ram[rd_addr];
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        key_colour_d = key_colour_q;
        pipe_valid_d = (state_q == S_SCAN);
        pipe_x_d     = scan_x_q;
        pipe_y_d     = scan_y_q;
        rd_valid_d   = pipe_valid_q;
        rd_x_d       = rd_x_q;
        rd_y_d       = rd_y_q;
        rd_colour_d  = rd_colour_q;
        match_d      = match_q;
        sum_d        = sum_q;
        oob_d        = oob_q;
        done_d       = (state_q == S_DONE);

        if (vga_plot && !in_range && (oob_q != 8'hFF)) begin
            oob_d = oob_q + 8'd1;
        end

        // Output stage: the RAM word read last cycle becomes a streamed beat.
        if (pipe_valid_q) begin
            rd_x_d      = pipe_x_q;
            rd_y_d      = pipe_y_q;
            rd_colour_d = ram_rdata_q;
            match_d     = match_q + 15'(ram_rdata_q == key_colour_q);
            sum_d       = sum_q + 16'(ram_rdata_q);
        end

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    key_colour_d = scan_colour;
                    match_d      = '0;
                    sum_d        = '0;
                    scan_x_d     = '0;
                    scan_y_d     = '0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_d = S_FLUSH;
                end else if (scan_x_q == 8'(WIDTH - 1)) begin
                    scan_x_d = '0;
                    scan_y_d = scan_y_q + 7'd1;
                end else begin
                    scan_x_d = scan_x_q + 8'd1;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!scan_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            key_colour_q <= '0;
            pipe_valid_q <= 1'b0;
            pipe_x_q     <= '0;
            pipe_y_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            rd_colour_q  <= '0;
            match_q      <= '0;
            sum_q        <= '0;
            oob_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            key_colour_q <= key_colour_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_x_q     <= pipe_x_d;
            pipe_y_q     <= pipe_y_d;
            rd_valid_q   <= rd_valid_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            rd_colour_q  <= rd_colour_d;
            match_q      <= match_d;
            sum_q        <= sum_d;
            oob_q        <= oob_d;
            done_q       <= done_d;
        end
    end

    assign scan_done   = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign rd_colour   = rd_colour_q;
    assign match_count = match_q;
    assign checksum    = sum_q;
    assign oob_count   = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_plot_readback.sv
// ============================================================================
// Module   : tb_plot_readback
// Purpose  : Directed self-checking bench for plot_readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plot_readback;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        scan_start;
    logic [2:0]  scan_colour;
    logic        scan_done;
    logic        rd_valid;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic [14:0] match_count;
    logic [15:0] checksum;
    logic [7:0]  oob_count;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    plot_readback #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .scan_start  (scan_start),
        .scan_colour (scan_colour),
        .scan_done   (scan_done),
        .rd_valid    (rd_valid),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_colour   (rd_colour),
        .match_count (match_count),
        .checksum    (checksum),
        .oob_count   (oob_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},   32'(scan_done),   0);
        check({tag, "_valid"},  32'(rd_valid),    0);
        check({tag, "_x"},      32'(rd_x),        0);
        check({tag, "_y"},      32'(rd_y),        0);
        check({tag, "_colour"}, 32'(rd_colour),   0);
        check({tag, "_match"},  32'(match_count), 0);
        check({tag, "_sum"},    32'(checksum),    0);
        check({tag, "_oob"},    32'(oob_count),   0);
    endtask

    // Full scan; edge 0 is the edge that samples scan_start in IDLE.
    task automatic run_scan(input string tag, input logic [2:0] colour, input bit collide,
                            input int hold, input int exp_match, input int exp_sum,
                            input logic [2:0] exp_first, input logic [2:0] exp_last);
        int edge_n = 0;
        int beats = 0;
        int first_edge = -1;
        int order_err = 0;
        int ex = 0;
        int ey = 0;
        logic [2:0] first_c = '0;
        logic [2:0] last_c = '0;
        logic [7:0] last_x = '0;
        logic [6:0] last_y = '0;
        scan_colour = colour;
        scan_start  = 1'b1;
        tick();
        if (collide) begin
            vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'b111; vga_plot = 1'b1;
        end
        while (scan_done !== 1'b1 && edge_n < 20000) begin
            tick();
            edge_n++;
            if (edge_n == 1) vga_plot = 1'b0;
            if (hold == 0 && edge_n == 100) scan_start = 1'b0;
            if (rd_valid === 1'b1) begin
                beats++;
                if (beats == 1) begin
                    first_edge = edge_n;
                    first_c    = rd_colour;
                end
                if (rd_x !== 8'(ex) || rd_y !== 7'(ey)) order_err++;
                if (ex == WIDTH - 1) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
                last_x = rd_x; last_y = rd_y; last_c = rd_colour;
            end
        end
        check({tag, "_first_edge"},  32'(first_edge), 2);
        check({tag, "_done_edge"},   32'(edge_n), 19202);
        check({tag, "_beats"},       32'(beats), 19200);
        check({tag, "_order_err"},   32'(order_err), 0);
        check({tag, "_match"},       32'(match_count), 32'(exp_match));
        check({tag, "_checksum"},    32'(checksum), 32'(exp_sum));
        check({tag, "_first_colour"}, 32'(first_c), 32'(exp_first));
        check({tag, "_last_x"},      32'(last_x), 159);
        check({tag, "_last_y"},      32'(last_y), 119);
        check({tag, "_last_colour"}, 32'(last_c), 32'(exp_last));
        check({tag, "_valid_at_done"}, 32'(rd_valid), 0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) tick();
            check({tag, "_hold_done"},  32'(scan_done), 1);
            check({tag, "_hold_valid"}, 32'(rd_valid), 0);
            check({tag, "_hold_match"}, 32'(match_count), 32'(exp_match));
            check({tag, "_hold_sum"},   32'(checksum), 32'(exp_sum));
            scan_start = 1'b0;
            tick();
            check({tag, "_done_lag"}, 32'(scan_done), 1);
        end
        tick();
        check({tag, "_done_drop"}, 32'(scan_done), 0);
    endtask

    initial begin
        int beats;
        int n;
        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        scan_start = 1'b0; scan_colour = '0;
        #22;
        check_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();

        // RED fill of every pixel.
        vga_colour = 3'b100;
        vga_plot   = 1'b1;
        for (int y = 0; y < HEIGHT; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                vga_x = 8'(x); vga_y = 7'(y);
                tick();
            end
        end
        vga_plot = 1'b0;
        check("fill_oob", 32'(oob_count), 0);

        plot(8'd160, 7'd0,   3'b001);
        plot(8'd0,   7'd120, 3'b001);
        plot(8'd255, 7'd127, 3'b001);
        check("oob_three", 32'(oob_count), 3);

        // RED scan; WHITE written at (0,0) in the same cycle it is read.
        run_scan("red", 3'b100, 1'b1, 0, 19200, 11264, 3'b100, 3'b100);

        vga_plot = 1'b1; vga_colour = 3'b011;
        for (int i = 0; i < 300; i++) begin
            vga_x = 8'(160 + (i % 96)); vga_y = 7'(i % 128);
            tick();
        end
        vga_plot = 1'b0;
        check("oob_saturate", 32'(oob_count), 255);

        plot(8'd159, 7'd119, 3'b010);
        // (0,0)=WHITE, (159,119)=GREEN, rest RED: 19198*4+7+2 mod 65536.
        run_scan("green", 3'b010, 1'b0, 5, 1, 11265, 3'b111, 3'b010);

        // New scan restarts counters; reset at beat 5000.
        scan_colour = 3'b100;
        scan_start  = 1'b1;
        tick();
        beats = 0;
        n = 0;
        while (beats < 5000 && n < 6000) begin
            tick();
            n++;
            if (rd_valid === 1'b1) begin
                beats++;
                if (beats == 1) begin
                    check("restart_match", 32'(match_count), 0);
                    check("restart_sum",   32'(checksum), 7);
                end
            end
        end
        check("mid_beats",  32'(beats), 5000);
        check("mid_match",  32'(match_count), 4999);
        check("mid_x",      32'(rd_x), 39);
        check("mid_y",      32'(rd_y), 31);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        scan_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_done",  32'(scan_done), 0);
        check("idle_valid", 32'(rd_valid), 0);

        scan_start = 1'b1;
        tick();
        tick();
        check("rescan_e1_valid", 32'(rd_valid), 0);
        tick();
        check("rescan_e2_valid",  32'(rd_valid), 1);
        check("rescan_e2_x",      32'(rd_x), 0);
        check("rescan_e2_y",      32'(rd_y), 0);
        check("rescan_e2_colour", 32'(rd_colour), 7);
        rst_n = 1'b0;
        scan_start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
